// File: rtl/piso_shift_reg_8bit_pkg.sv
// rtl/piso_shift_reg_8bit_pkg.sv - shared types and constants for the PISO shifter and its bit counter
package piso_shift_reg_8bit_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_DEF = 8;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/piso_shift_reg_8bit_if.sv
// rtl/piso_shift_reg_8bit_if.sv - parallel load handshake and serial output bundle
interface piso_shift_reg_8bit_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic             d_ready;
  logic             shift_en;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output d, d_valid, shift_en,
    input  d_ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  d, d_valid, shift_en,
    output d_ready, sout, sout_valid, busy, done
  );

endinterface

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - bit position counter, cleared on load, saturates at WIDTH-1
module piso_bit_counter
  import piso_shift_reg_8bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic last
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (inc && !last) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == LAST_IDX);

endmodule

// File: rtl/piso_shift_reg_8bit.sv
// rtl/piso_shift_reg_8bit.sv - parallel-in serial-out shifter paced by an external bit strobe
module piso_shift_reg_8bit
  import piso_shift_reg_8bit_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  piso_shift_reg_8bit_if.slave  bus
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sr;
  logic             last;
  logic             last_shift;
  logic             ready;
  logic             accept;
  logic             done_q;
  logic             sout_c;
  logic             valid_c;

  // Ready during the last-bit strobe lets a new word follow with no gap.
  assign last_shift = (state == SHIFT) && last && bus.shift_en;
  assign ready      = (state == IDLE) || last_shift;
  assign accept     = bus.d_valid && ready;

  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .inc  ((state == SHIFT) && bus.shift_en),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr     <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_shift;
      if (accept) begin
        sr <= bus.d;
      end else if ((state == SHIFT) && bus.shift_en) begin
        sr <= MSB_FIRST ? (sr << 1) : (sr >> 1);
      end
    end
  end

  always_comb begin
    sout_c  = 1'b0;
    valid_c = 1'b0;
    if (state == SHIFT) begin
      sout_c  = MSB_FIRST ? sr[WIDTH-1] : sr[0];
      valid_c = 1'b1;
    end
  end

  assign bus.d_ready    = ready;
  assign bus.sout       = sout_c;
  assign bus.sout_valid = valid_c;
  assign bus.busy       = valid_c;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_shift_reg_8bit.sv
// tb/tb_piso_shift_reg_8bit.sv - bench for piso_shift_reg_8bit, MSB-first and LSB-first instances
module tb_piso_shift_reg_8bit;

  localparam int W = 8;

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  piso_shift_reg_8bit_if #(.WIDTH(W)) bus_m ();
  piso_shift_reg_8bit_if #(.WIDTH(W)) bus_l ();

  piso_shift_reg_8bit #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bus_m));
  piso_shift_reg_8bit #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bus_l));

  int pass_cnt = 0;
  int total_cnt = 0;

  vec_t       tbl [7];
  logic [7:0] w;
  logic [7:0] sm, sl;
  logic [15:0] s16;
  int nm, nl, bl, dm, dl, nvalid, rdy_err, dones;
  bit qm [$];
  bit ql [$];
  bit edm, edl, dv, se, rm, rl;
  logic [7:0] dw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus_m.d = '0; bus_m.d_valid = 1'b0; bus_m.shift_en = 1'b0;
    bus_l.d = '0; bus_l.d_valid = 1'b0; bus_l.shift_en = 1'b0;
  endtask

  task automatic run_word(input logic [7:0] word, output logic [7:0] om, output logic [7:0] ol,
                          output int cm, output int cl, output int bsy, output int pm, output int pl);
    om = '0; ol = '0; cm = 0; cl = 0; bsy = 0; pm = 0; pl = 0;
    bus_m.d = word; bus_l.d = word;
    bus_m.d_valid = 1'b1; bus_l.d_valid = 1'b1;
    bus_m.shift_en = 1'b1; bus_l.shift_en = 1'b1;
    tick();
    bus_m.d_valid = 1'b0; bus_l.d_valid = 1'b0;
    repeat (12) begin
      if (bus_m.sout_valid) begin om = {om[6:0], bus_m.sout}; cm++; end
      if (bus_l.sout_valid) begin ol = {ol[6:0], bus_l.sout}; cl++; end
      if (bus_l.busy) bsy++;
      if (bus_m.done) pm++;
      if (bus_l.done) pl++;
      tick();
    end
  endtask

  function automatic logic [4:0] model_out(input int sz, input bit front, input bit strobe, input bit ed);
    return {(sz == 0) || (sz == 1 && strobe), (sz > 0) ? front : 1'b0, sz > 0, sz > 0, ed};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'hA5, 8'hA5, 8'hA5};
    tbl[1] = '{8'h01, 8'h01, 8'h80};
    tbl[2] = '{8'hF0, 8'hF0, 8'h0F};
    tbl[3] = '{8'hC3, 8'hC3, 8'hC3};
    tbl[4] = '{8'h12, 8'h12, 8'h48};
    tbl[5] = '{8'hE1, 8'hE1, 8'h87};
    tbl[6] = '{8'h3C, 8'h3C, 8'h3C};

    idle_inputs();
    rst = 1'b0;
    tick(); tick();
    check("reset_msb", 32'({bus_m.sout, bus_m.sout_valid, bus_m.busy, bus_m.done}), 32'(4'b0000));
    check("reset_lsb", 32'({bus_l.sout, bus_l.sout_valid, bus_l.busy, bus_l.done}), 32'(4'b0000));
    rst = 1'b1;
    tick();
    check("idle_ready", 32'({bus_m.d_ready, bus_l.d_ready}), 32'(2'b11));

    // Single A5 word, MSB first, full-rate strobe
    w = 8'hA5;
    bus_m.d = w; bus_m.d_valid = 1'b1; bus_m.shift_en = 1'b1;
    #1;
    check("t1_ready", 32'(bus_m.d_ready), 32'(1));
    tick();
    bus_m.d_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t1_bit", 32'({bus_m.sout, bus_m.sout_valid, bus_m.done}), 32'({w[7-i], 1'b1, 1'b0}));
      tick();
    end
    check("t1_done", 32'({bus_m.done, bus_m.d_ready, bus_m.sout_valid}), 32'(3'b110));
    tick();
    check("t1_done_clr", 32'(bus_m.done), 32'(0));
    idle_inputs();
    tick();

    for (int k = 0; k < 7; k++) begin
      run_word(tbl[k].word, sm, sl, nm, nl, bl, dm, dl);
      check("tbl_msb", 32'(sm), 32'(tbl[k].exp_msb));
      check("tbl_lsb", 32'(sl), 32'(tbl[k].exp_lsb));
      check("tbl_len", 32'({8'(nm), 8'(nl), 8'(bl)}), 32'({8'd8, 8'd8, 8'd8}));
      check("tbl_done", 32'({8'(dm), 8'(dl)}), 32'({8'd1, 8'd1}));
    end
    idle_inputs();

    // Back-to-back A5 then 3C with d_valid held
    s16 = '0; nvalid = 0; rdy_err = 0; dones = 0;
    bus_m.d = 8'hA5; bus_m.d_valid = 1'b1; bus_m.shift_en = 1'b1;
    tick();
    bus_m.d = 8'h3C;
    for (int c = 1; c <= 18; c++) begin
      if (c == 9) bus_m.d_valid = 1'b0;
      #1;
      if (bus_m.sout_valid) begin s16 = {s16[14:0], bus_m.sout}; nvalid++; end
      if (c <= 16 && (bus_m.d_ready !== (c == 8 || c == 16))) rdy_err++;
      if (bus_m.done) dones++;
      tick();
    end
    check("b2b_stream", 32'(s16), 32'(16'hA53C));
    check("b2b_valid", 32'(nvalid), 32'(16));
    check("b2b_ready", 32'(rdy_err), 32'(0));
    check("b2b_done", 32'(dones), 32'(2));
    idle_inputs();
    tick();

    // Half-rate strobe: each bit held two cycles
    w = 8'hF0;
    bus_m.d = w; bus_m.d_valid = 1'b1; bus_m.shift_en = 1'b0;
    tick();
    bus_m.d_valid = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      bus_m.shift_en = (c % 2 == 0);
      #1;
      if (c <= 16)
        check("half_bit", 32'({bus_m.sout, bus_m.sout_valid, bus_m.done}), 32'({w[7-(c-1)/2], 1'b1, 1'b0}));
      else
        check("half_done", 32'({bus_m.sout, bus_m.sout_valid, bus_m.done}), 32'(3'b001));
      tick();
    end
    idle_inputs();
    tick();

    // Asynchronous reset after three bits of C3
    w = 8'hC3;
    bus_m.d = w; bus_m.d_valid = 1'b1; bus_m.shift_en = 1'b1;
    tick();
    bus_m.d_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_pre_bit", 32'({bus_m.sout, bus_m.sout_valid}), 32'({w[7-i], 1'b1}));
      tick();
    end
    #2;
    rst = 1'b0;
    #1;
    check("rst_async", 32'({bus_m.sout_valid, bus_m.sout, bus_m.busy, bus_m.done}), 32'(4'b0000));
    tick(); tick();
    check("rst_hold", 32'({bus_m.sout_valid, bus_m.busy, bus_m.done}), 32'(3'b000));
    rst = 1'b1;
    idle_inputs();
    tick();
    check("rst_no_done", 32'(bus_m.done), 32'(0));
    run_word(8'hFF, sm, sl, nm, nl, bl, dm, dl);
    check("post_rst_ff", 32'({sm, sl}), 32'(16'hFFFF));
    check("post_rst_len", 32'({8'(nm), 8'(dm)}), 32'({8'd8, 8'd1}));
    idle_inputs();

    // New word offered mid-flight is held off until the last-bit edge
    s16 = '0; nvalid = 0; rdy_err = 0;
    bus_m.d = 8'h96; bus_m.d_valid = 1'b1; bus_m.shift_en = 1'b1;
    tick();
    bus_m.d_valid = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (c == 3) begin bus_m.d = 8'h55; bus_m.d_valid = 1'b1; end
      if (c == 9) bus_m.d_valid = 1'b0;
      #1;
      if (c == 3) check("mid_ready", 32'(bus_m.d_ready), 32'(0));
      if (c >= 3 && c <= 7 && bus_m.d_ready) rdy_err++;
      if (c == 8 && !bus_m.d_ready) rdy_err++;
      if (bus_m.sout_valid) begin s16 = {s16[14:0], bus_m.sout}; nvalid++; end
      tick();
    end
    check("mid_stream", 32'(s16), 32'(16'h9655));
    check("mid_valid", 32'(nvalid), 32'(16));
    check("mid_ready_seq", 32'(rdy_err), 32'(0));
    idle_inputs();

    // Random traffic against a bit-queue reference model
    rst = 1'b0;
    tick();
    rst = 1'b1;
    qm.delete(); ql.delete(); edm = 1'b0; edl = 1'b0;
    for (int n = 0; n < 400; n++) begin
      dv = ($urandom % 4) != 0;
      se = ($urandom % 3) != 0;
      dw = 8'($urandom);
      bus_m.d = dw; bus_m.d_valid = dv; bus_m.shift_en = se;
      bus_l.d = dw; bus_l.d_valid = dv; bus_l.shift_en = se;
      #1;
      check("rnd_msb", 32'({bus_m.d_ready, bus_m.sout, bus_m.sout_valid, bus_m.busy, bus_m.done}),
            32'(model_out(qm.size(), (qm.size() > 0) ? qm[0] : 1'b0, se, edm)));
      check("rnd_lsb", 32'({bus_l.d_ready, bus_l.sout, bus_l.sout_valid, bus_l.busy, bus_l.done}),
            32'(model_out(ql.size(), (ql.size() > 0) ? ql[0] : 1'b0, se, edl)));
      rm = (qm.size() == 0) || (qm.size() == 1 && se);
      rl = (ql.size() == 0) || (ql.size() == 1 && se);
      edm = (qm.size() == 1) && se;
      edl = (ql.size() == 1) && se;
      if (se && qm.size() > 0) void'(qm.pop_front());
      if (se && ql.size() > 0) void'(ql.pop_front());
      if (dv && rm) begin
        qm.delete();
        for (int i = W - 1; i >= 0; i--) qm.push_back(dw[i]);
      end
      if (dv && rl) begin
        ql.delete();
        for (int i = 0; i < W; i++) ql.push_back(dw[i]);
      end
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
